// File: rtl/seg7_scan_reader_if.sv
// Segment/anode sample bus and decoded frame outputs of the 7-segment scan reader.
// The reader takes the slave view; whatever drives the display lines takes the master view.
interface seg7_scan_reader_if;
   logic [6:0]  i_seg;
   logic [3:0]  i_an;
   logic [15:0] o_value;
   logic [3:0]  o_bad;
   logic        o_valid;

   modport master (output i_seg, output i_an, input o_value, input o_bad, input o_valid);
   modport slave  (input i_seg, input i_an, output o_value, output o_bad, output o_valid);
endinterface

// File: rtl/seg7_scan_reader.sv
// Reads back a multiplexed 4-digit 7-segment display: debounces each scanned digit, decodes it
// to hex and publishes a complete frame once all four digits have been captured.
module seg7_scan_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic               i_clk,
   input logic               i_rst_n,
   seg7_scan_reader_if.slave bus
);

   // Count value at which the STABLE_CYCLES-th identical sample has been seen.
   localparam logic [7:0] AcceptCnt = 8'(STABLE_CYCLES - 1);

   logic [6:0]  seg_q, seg_prev_q;
   logic [3:0]  an_q, an_prev_q;
   logic [7:0]  cnt_q, cnt_d;
   logic        sample_ok, same, accept;
   logic [1:0]  digit;
   logic [3:0]  nib;
   logic        nib_bad;
   logic [15:0] shadow_q;
   logic [3:0]  shadow_bad_q;
   logic [3:0]  seen_q, seen_d;
   logic        frame_done;
   logic [15:0] value_q;
   logic [3:0]  bad_q;
   logic        valid_q;

   always_comb begin
      sample_ok = $onehot(an_q);
      same      = sample_ok && (an_q == an_prev_q) && (seg_q == seg_prev_q);
      cnt_d     = 8'd0;
      if (same) begin
         cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
      end
      // Saturation past AcceptCnt keeps a held digit from being accepted twice.
      accept = sample_ok && (cnt_d == AcceptCnt);
   end

   always_comb begin
      digit = 2'd0;
      case (an_q)
         4'b0010: digit = 2'd1;
         4'b0100: digit = 2'd2;
         4'b1000: digit = 2'd3;
         default: digit = 2'd0;
      endcase
   end

   always_comb begin
      nib     = 4'h0;
      nib_bad = 1'b0;
      case (seg_q)
         7'b1111110: nib = 4'h0;
         7'b0110000: nib = 4'h1;
         7'b1101101: nib = 4'h2;
         7'b1111001: nib = 4'h3;
         7'b0110011: nib = 4'h4;
         7'b1011011: nib = 4'h5;
         7'b1011111: nib = 4'h6;
         7'b1110000: nib = 4'h7;
         7'b1111111: nib = 4'h8;
         7'b1111011: nib = 4'h9;
         7'b1110111: nib = 4'hA;
         7'b0011111: nib = 4'hB;
         7'b1001110: nib = 4'hC;
         7'b0111101: nib = 4'hD;
         7'b1001111: nib = 4'hE;
         7'b1000111: nib = 4'hF;
         default:    nib_bad = 1'b1;
      endcase
   end

   // A digit accepted on the frame-complete edge starts the next frame.
   always_comb begin
      frame_done = (seen_q == 4'b1111);
      seen_d     = frame_done ? 4'b0000 : seen_q;
      if (accept) begin
         seen_d[digit] = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         seg_q        <= 7'd0;
         an_q         <= 4'd0;
         seg_prev_q   <= 7'd0;
         an_prev_q    <= 4'd0;
         cnt_q        <= 8'd0;
         shadow_q     <= 16'h0000;
         shadow_bad_q <= 4'b0000;
         seen_q       <= 4'b0000;
         value_q      <= 16'h0000;
         bad_q        <= 4'b0000;
         valid_q      <= 1'b0;
      end else begin
         seg_q      <= bus.i_seg;
         an_q       <= bus.i_an;
         seg_prev_q <= seg_q;
         an_prev_q  <= an_q;
         cnt_q      <= cnt_d;
         seen_q     <= seen_d;
         valid_q    <= frame_done;
         if (accept) begin
            shadow_q[{digit, 2'b00} +: 4] <= nib;
            shadow_bad_q[digit]           <= nib_bad;
         end
         if (frame_done) begin
            value_q <= shadow_q;
            bad_q   <= shadow_bad_q;
         end
      end
   end

   assign bus.o_value = value_q;
   assign bus.o_bad   = bad_q;
   assign bus.o_valid = valid_q;

endmodule
